hex_word_serializer: RTL

HEX_WORD_SERIALIZER -- requirements
Module: hex_word_serializer

---
 rtl/hex_word_serializer_pkg.sv | 6 +
 rtl/dc_hex_ascii.sv | 7 +
 rtl/hex_word_serializer.sv | 69 ++++++
 3 files changed

// File: rtl/hex_word_serializer_pkg.sv
// hex_word_serializer_pkg: shared state encoding and line-ending characters for the hex serializer
package hex_word_serializer_pkg;
  typedef enum logic [1:0] {IDLE, DIGIT, CR, LF} state_t;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
endpackage

// File: rtl/dc_hex_ascii.sv
// dc_hex_ascii: combinational nibble to uppercase hex ASCII decoder
module dc_hex_ascii (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);
  always_comb ascii = nibble < 4'd10 ? 8'h30 + {4'h0, nibble} : 8'h37 + {4'h0, nibble};
endmodule

// File: rtl/hex_word_serializer.sv
// hex_word_serializer: prints a word as uppercase hex ASCII, MSB nibble first, over valid/ready
// HEX_SER_NEWLINE_EN appends CR LF after every word
module hex_word_serializer
  import hex_word_serializer_pkg::*;
#(
  parameter int NIBBLES = 8
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [4*NIBBLES-1:0]   IN_DATA,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  output logic [7:0]             OUT_CHAR,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic                   BUSY
);
  localparam int W = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES + 1);
  state_t state, state_n;
  logic [W-1:0] shift, shift_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0] ascii, char_n;
  logic hs_in, hs_out, dig_hs;
  assign hs_in = IN_VALID && IN_READY;
  assign hs_out = OUT_VALID && OUT_READY;
  assign dig_hs = state == DIGIT && hs_out;
  always_ff @(posedge CLK) state <= !RST_N ? IDLE : state_n;
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = hs_in ? DIGIT : IDLE;
`ifdef HEX_SER_NEWLINE_EN
    else if (hs_out) state_n = state == CR ? LF : state == LF ? IDLE : cnt == CW'(1) ? CR : DIGIT;
`else
    else if (hs_out) state_n = cnt == CW'(1) ? IDLE : DIGIT;
`endif
  end
  always_comb begin
    IN_READY = RST_N && state == IDLE;
    BUSY = state != IDLE;
  end
  // the character register is loaded from the next shift value so the first digit appears right after the handshake
  always_comb begin
    shift_n = hs_in ? IN_DATA : dig_hs ? shift << 4 : shift;
    cnt_n = hs_in ? CW'(NIBBLES) : dig_hs ? cnt - CW'(1) : cnt;
`ifdef HEX_SER_NEWLINE_EN
    char_n = state_n == DIGIT ? ascii : state_n == CR ? ASCII_CR : state_n == LF ? ASCII_LF : OUT_CHAR;
`else
    char_n = state_n == DIGIT ? ascii : OUT_CHAR;
`endif
  end
  dc_hex_ascii u_dec (
    .nibble(shift_n[W-1 -: 4]),
    .ascii (ascii)
  );
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      shift <= '0;
      cnt <= '0;
      OUT_VALID <= 1'b0;
      OUT_CHAR <= 8'h00;
    end else begin
      shift <= shift_n;
      cnt <= cnt_n;
      OUT_VALID <= state_n != IDLE;
      OUT_CHAR <= char_n;
    end
  end
endmodule
